axi_light_mem_slave: RTL and testbench

AXI4-lite responder that terminates one `if_axi_light` master port, such as a PiXo core wrapper, into a word-addressed on-chip memory. Write and read channels run independently. It is the memory endpoint behind the PiXo interconnect and serves instruction fetch, stack and data for one node. The data sizing covers the default 40000-byte stack top.

---
 rtl/pixo_axi_slv_pkg.sv | 22 ++
 rtl/pixo_byte_ram.sv | 25 ++
 rtl/axi_light_mem_slave.sv | 119 +++++++++++
 tb/tb_axi_light_mem_slave.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixo_axi_slv_pkg.sv
// pixo_axi_slv_pkg: shared types, widths and address helpers for axi_light_mem_slave.
// R_PIPE exists only when AXI_SLV_RD_REG_EN is defined.
package pixo_axi_slv_pkg;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = 4;

    typedef enum logic [2:0] {W_INIT, W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
`ifdef AXI_SLV_RD_REG_EN
    typedef enum logic [1:0] {R_INIT, R_IDLE, R_PIPE, R_VALID} r_state_t;
`else
    typedef enum logic [1:0] {R_INIT, R_IDLE, R_VALID} r_state_t;
`endif

    function automatic logic addr_in_range(input logic [AXI_ADDR_W-1:0] addr, base, words);
        return addr >= base && ((addr - base) >> 2) < words;
    endfunction

    function automatic logic [AXI_ADDR_W-1:0] word_index(input logic [AXI_ADDR_W-1:0] addr, base);
        return (addr - base) >> 2;
    endfunction
endpackage

// File: rtl/pixo_byte_ram.sv
// pixo_byte_ram: MEM_WORDS x 32 RAM, byte-enabled write port and synchronous read port.
module pixo_byte_ram
    import pixo_axi_slv_pkg::*;
#(
    parameter int MEM_WORDS = 10000,
    parameter int AW = $clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AXI_STRB_W-1:0] be,
    input  logic [AW-1:0]         waddr,
    input  logic [AXI_DATA_W-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [AXI_DATA_W-1:0] rdata
);
    logic [AXI_DATA_W-1:0] mem [MEM_WORDS];

    // Nonblocking read and write on one edge: a same-address read sees the old word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < AXI_STRB_W; i++)
            if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/axi_light_mem_slave.sv
// axi_light_mem_slave: AXI4-lite responder terminating one master into word-addressed RAM.
// Define AXI_SLV_RD_REG_EN to add a read output register (2-cycle read latency).
module axi_light_mem_slave
    import pixo_axi_slv_pkg::*;
#(
    parameter int                    MEM_WORDS = 10000,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int                    NODE_ID   = 0
) (
    input  logic                  clk,
    input  logic                  res_n,
    input  logic                  s_axi_awvalid,
    input  logic [AXI_ADDR_W-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_wvalid,
    input  logic [AXI_DATA_W-1:0] s_axi_wdata,
    input  logic [AXI_STRB_W-1:0] s_axi_wstrb,
    input  logic                  s_axi_bready,
    input  logic                  s_axi_arvalid,
    input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_rready,
    output logic                  s_axi_awready,
    output logic                  s_axi_wready,
    output logic                  s_axi_bvalid,
    output logic                  s_axi_arready,
    output logic                  s_axi_rvalid,
    output logic [AXI_DATA_W-1:0] s_axi_rdata,
    output logic                  oor
);
    localparam int AW = $clog2(MEM_WORDS);

    w_state_t              w_state;
    r_state_t              r_state;
    logic [AXI_ADDR_W-1:0] aw_q, c_addr, w_idx, r_idx;
    logic [AXI_DATA_W-1:0] wd_q, c_data, ram_q;
    logic [AXI_STRB_W-1:0] ws_q, c_strb;
    logic                  aw_hs, w_hs, ar_hs, commit, c_ok, ar_ok, r_oor_q;
    logic                  unused_ok;

    assign s_axi_awready = w_state == W_IDLE || w_state == W_HAVE_W;
    assign s_axi_wready  = w_state == W_IDLE || w_state == W_HAVE_AW;
    assign s_axi_bvalid  = w_state == W_RESP;
    assign s_axi_arready = r_state == R_IDLE;
    assign s_axi_rvalid  = r_state == R_VALID;
    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    // A write commits on the edge where its second half arrives, using the latched first half.
    assign commit = (w_state == W_IDLE && aw_hs && w_hs) || (w_state == W_HAVE_AW && w_hs) || (w_state == W_HAVE_W && aw_hs);
    assign c_addr = w_state == W_HAVE_AW ? aw_q : s_axi_awaddr;
    assign c_data = w_state == W_HAVE_W ? wd_q : s_axi_wdata;
    assign c_strb = w_state == W_HAVE_W ? ws_q : s_axi_wstrb;
    assign c_ok   = addr_in_range(c_addr, BASE_ADDR, MEM_WORDS);
    assign ar_ok  = addr_in_range(s_axi_araddr, BASE_ADDR, MEM_WORDS);
    assign w_idx  = word_index(c_addr, BASE_ADDR);
    assign r_idx  = word_index(s_axi_araddr, BASE_ADDR);
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, w_idx[AXI_ADDR_W-1:AW], r_idx[AXI_ADDR_W-1:AW], NODE_ID == 0};

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            w_state <= W_INIT;
            r_state <= R_INIT;
            r_oor_q <= 1'b0;
            oor     <= 1'b0;
        end else begin
            w_state <= w_state == W_INIT ? W_IDLE
                     : commit ? W_RESP
                     : w_state == W_IDLE && aw_hs ? W_HAVE_AW
                     : w_state == W_IDLE && w_hs ? W_HAVE_W
                     : w_state == W_RESP && s_axi_bready ? W_IDLE
                     : w_state;
`ifdef AXI_SLV_RD_REG_EN
            r_state <= r_state == R_INIT ? R_IDLE
                     : ar_hs ? R_PIPE
                     : r_state == R_PIPE ? R_VALID
                     : r_state == R_VALID && s_axi_rready ? R_IDLE
                     : r_state;
`else
            r_state <= r_state == R_INIT ? R_IDLE
                     : ar_hs ? R_VALID
                     : r_state == R_VALID && s_axi_rready ? R_IDLE
                     : r_state;
`endif
            r_oor_q <= ar_hs ? !ar_ok : r_oor_q;
            oor     <= oor || (commit && !c_ok) || (ar_hs && !ar_ok);
        end
    end

    always_ff @(posedge clk) begin
        aw_q <= aw_hs ? s_axi_awaddr : aw_q;
        wd_q <= w_hs ? s_axi_wdata : wd_q;
        ws_q <= w_hs ? s_axi_wstrb : ws_q;
    end

`ifdef AXI_SLV_RD_REG_EN
    logic [AXI_DATA_W-1:0] rdata_q;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) rdata_q <= '0;
        else if (r_state == R_PIPE) rdata_q <= r_oor_q ? '0 : ram_q;
    end

    assign s_axi_rdata = rdata_q;
`else
    assign s_axi_rdata = s_axi_rvalid && !r_oor_q ? ram_q : '0;
`endif

    pixo_byte_ram #(.MEM_WORDS(MEM_WORDS)) u_ram (
        .clk   (clk),
        .we    (commit && c_ok),
        .be    (c_strb),
        .waddr (w_idx[AW-1:0]),
        .wdata (c_data),
        .re    (ar_hs),
        .raddr (r_idx[AW-1:0]),
        .rdata (ram_q)
    );
endmodule

// File: tb/tb_axi_light_mem_slave.sv
// tb_axi_light_mem_slave: directed bench for axi_light_mem_slave with a queue-based reference model.
module tb_axi_light_mem_slave;
    localparam int          MW = 10000;
    localparam logic [31:0] BA = 32'h0000_0000;
`ifdef AXI_SLV_RD_REG_EN
    localparam int RLAT = 2;
`else
    localparam int RLAT = 1;
`endif

    logic        clk = 0, res_n = 0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] awaddr = 0, wdata = 0, araddr = 0;
    logic [3:0]  wstrb = 0;
    logic [2:0]  awprot = 0, arprot = 0;
    logic        awready, wready, bvalid, arready, rvalid, oor;
    logic [31:0] rdata;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    axi_light_mem_slave dut (
        .clk(clk), .res_n(res_n),
        .s_axi_awvalid(awvalid), .s_axi_awaddr(awaddr), .s_axi_awprot(awprot),
        .s_axi_wvalid(wvalid), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_bready(bready),
        .s_axi_arvalid(arvalid), .s_axi_araddr(araddr), .s_axi_arprot(arprot),
        .s_axi_rready(rready),
        .s_axi_awready(awready), .s_axi_wready(wready), .s_axi_bvalid(bvalid),
        .s_axi_arready(arready), .s_axi_rvalid(rvalid), .s_axi_rdata(rdata),
        .oor(oor)
    );

    // Reference model: memory by word index, pending AW/W halves, outstanding responses.
    logic [31:0] mm [int];
    logic [31:0] awq[$], wdq[$], rq[$];
    logic [3:0]  wsq[$];
    int          b_pend = 0, r_age = 0;
    logic        m_oor = 0, m_up = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        longint off = longint'(a) - longint'(BA);
        return off >= 0 && off / 4 < MW;
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'((a - BA) >> 2);
    endfunction

    function automatic void mreset();
        awq.delete(); wdq.delete(); wsq.delete(); rq.delete();
        b_pend = 0; r_age = 0; m_oor = 0; m_up = 0;
    endfunction

    initial forever begin
        logic [31:0] a, d, t;
        logic [3:0]  s;
        @(posedge clk);
        if (!res_n) mreset();
        else begin
            if (rvalid && rready) void'(rq.pop_front());
            if (rq.size() > 0) r_age++;
            if (arvalid && arready) begin
                rq.push_back(in_rng(araddr) && mm.exists(idx(araddr)) ? mm[idx(araddr)] : 32'h0);
                r_age = 0;
                if (!in_rng(araddr)) m_oor = 1;
            end
            if (bvalid && bready) b_pend--;
            if (awvalid && awready) awq.push_back(awaddr);
            if (wvalid && wready) begin
                wdq.push_back(wdata);
                wsq.push_back(wstrb);
            end
            if (awq.size() > 0 && wdq.size() > 0) begin
                a = awq.pop_front(); d = wdq.pop_front(); s = wsq.pop_front();
                if (in_rng(a)) begin
                    t = mm.exists(idx(a)) ? mm[idx(a)] : 32'h0;
                    for (int b = 0; b < 4; b++) if (s[b]) t[8*b +: 8] = d[8*b +: 8];
                    mm[idx(a)] = t;
                end else m_oor = 1;
                b_pend++;
            end
            m_up = 1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!res_n) begin
            mreset();
            chk("rst_outputs", {awready, wready, bvalid, arready, rvalid, oor, rdata}, 64'h0);
        end else begin
            chk("awready", awready, m_up && b_pend == 0 && awq.size() == 0);
            chk("wready", wready, m_up && b_pend == 0 && wdq.size() == 0);
            chk("arready", arready, m_up && rq.size() == 0);
            chk("bvalid", bvalid, b_pend > 0);
            chk("rvalid", rvalid, rq.size() > 0 && r_age >= RLAT - 1);
            if (rvalid && rq.size() > 0) chk("rdata", rdata, rq[0]);
            chk("oor", oor, m_oor);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // lead = cycles W is presented before AW; returns at the first negedge after commit.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
        int n = 0;
        bit ad = 0, wd = 0, ag, wg;
        @(negedge clk);
        wvalid = 1; wdata = d; wstrb = s;
        if (lead == 0) begin awvalid = 1; awaddr = a; end
        while (!(ad && wd) && n < 50) begin
            ag = awvalid && awready;
            wg = wvalid && wready;
            @(negedge clk);
            n++;
            if (ag) begin awvalid = 0; ad = 1; end
            if (wg) begin wvalid = 0; wd = 1; end
            if (n == lead) begin awvalid = 1; awaddr = a; end
        end
        chk("wr_accept", {ad, wd}, 2'b11);
        chk("b_latency", bvalid, 1);
    endtask

    task automatic bresp();
        int n = 0;
        bready = 1;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        chk("b_seen", bvalid, 1);
        @(negedge clk);
        bready = 0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] q, output int lat);
        int n = 0;
        @(negedge clk);
        arvalid = 1; araddr = a;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        chk("ar_accept", arready, 1);
        @(negedge clk);
        arvalid = 0; lat = 1;
        while (!rvalid && lat < 10) begin @(negedge clk); lat++; end
        q = rdata; rready = 1;
        @(negedge clk);
        rready = 0;
    endtask

    initial begin
        logic [31:0] q;
        int lat, n;
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_oor", oor, 0);
        res_n = 1;
        #1 chk("init_arready", arready, 0);
        @(negedge clk);
        chk("up_readies", {awready, wready, arready}, 3'b111);

        // plain write then read
        wr(32'h100, 32'hDEAD_BEEF, 4'hF, 0);
        bresp();
        rd(32'h100, q, lat);
        chk("rd_100", q, 32'hDEAD_BEEF);
        chk("rd_latency", lat, RLAT);

        // W three cycles ahead of AW, partial strobe
        wr(32'h200, 32'hFFFF_FFFF, 4'hF, 0);
        bresp();
        wr(32'h200, 32'h1122_3344, 4'b0101, 3);
        bresp();
        rd(32'h200, q, lat);
        chk("rd_strobe", q, 32'hFF22_FF44);
        wr(32'h200, 32'hCAFE_0000, 4'h0, 0);
        bresp();
        rd(32'h200, q, lat);
        chk("rd_nostrobe", q, 32'hFF22_FF44);

        // bready held low while a second write waits
        wr(32'h300, 32'hA5A5_0001, 4'hF, 0);
        awvalid = 1; awaddr = 32'h304; wvalid = 1; wdata = 32'h5A5A_0002; wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            chk("hold_state", {bvalid, awready, wready}, 3'b100);
            @(negedge clk);
        end
        bready = 1;
        @(negedge clk);
        bready = 0;
        chk("after_b_readies", {bvalid, awready, wready}, 3'b011);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("pend_bvalid", bvalid, 1);
        bresp();
        rd(32'h300, q, lat);
        chk("rd_300", q, 32'hA5A5_0001);
        rd(32'h304, q, lat);
        chk("rd_304", q, 32'h5A5A_0002);

        // same-edge read and commit
        wr(32'h20, 32'h5, 4'hF, 0);
        bresp();
        @(negedge clk);
        arvalid = 1; araddr = 32'h20;
        awvalid = 1; awaddr = 32'h20; wvalid = 1; wdata = 32'h7; wstrb = 4'hF;
        chk("same_readies", {arready, awready, wready}, 3'b111);
        @(negedge clk);
        arvalid = 0; awvalid = 0; wvalid = 0;
        n = 0;
        while (!rvalid && n < 10) begin @(negedge clk); n++; end
        chk("same_edge_old", rdata, 32'h5);
        rready = 1;
        @(negedge clk);
        rready = 0;
        bresp();
        rd(32'h20, q, lat);
        chk("same_edge_new", q, 32'h7);

        // out of range
        wr(32'h9C3C, 32'h0BAD_F00D, 4'hF, 0);
        bresp();
        chk("oor_clear", oor, 0);
        rd(32'h9C40, q, lat);
        chk("oor_rdata", q, 32'h0);
        chk("oor_set", oor, 1);
        wr(32'h9C40, 32'h1234_5678, 4'hF, 0);
        bresp();
        chk("oor_sticky", oor, 1);
        rd(32'h9C3C, q, lat);
        chk("last_word", q, 32'h0BAD_F00D);

        // reset while rvalid is high
        @(negedge clk);
        arvalid = 1; araddr = 32'h100;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 10) begin @(negedge clk); n++; end
        chk("pre_rst_rvalid", rvalid, 1);
        #1 res_n = 0;
        #1 chk("mid_rst_outputs", {rvalid, arready, bvalid, oor, rdata}, 36'h0);
        repeat (2) @(negedge clk);
        res_n = 1;
        #1 chk("rel_arready", arready, 0);
        @(negedge clk);
        chk("rel1_arready", arready, 1);
        rd(32'h100, q, lat);
        chk("mem_kept", q, 32'hDEAD_BEEF);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
